// File: rtl/hub75_pkg.sv
// HUB75 scan controller shared types and default geometry.
// Imported by the scan controller top and its display timer.
package hub75_pkg;

    localparam int VPIXEL_D   = 64;
    localparam int SEGMENTS_D = 2;
    localparam int BPP_D      = 8;
    localparam int WAIT_WD_D  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT,
        S_BLANK_PRE,
        S_LATCH,
        S_BLANK_POST,
        S_DISPLAY
    } state_t;

    // A blanking interval is never shorter than one cycle.
    function automatic logic [7:0] blank_len(input logic [7:0] b);
        return (b == 8'd0) ? 8'd1 : b;
    endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Binary-coded-modulation display timer: loads plane length and
// lit time, counts both down, flags expiry of the full plane length.
module hub75_bcm_timer
    import hub75_pkg::*;
#(
    parameter int W = WAIT_WD_D + BPP_D
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] len,
    input  logic [W-1:0] on_len,
    output logic         expired,
    output logic         lit
);

    logic [W-1:0] cnt;
    logic [W-1:0] on_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            on_cnt <= '0;
        end else if (load) begin
            cnt    <= len;
            on_cnt <= on_len;
        end else begin
            if (cnt != '0)
                cnt <= cnt - 1'b1;
            if (on_cnt != '0)
                on_cnt <= on_cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);
    assign lit     = (on_cnt != '0);

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 row/bit-plane scan controller with one-plane shift pipelining.
// Define HUB75_SCAN_BRIGHTNESS_EN to scale lit time by i_brightness.
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int VPIXEL_P   = VPIXEL_D,
    parameter int SEGMENTS_P = SEGMENTS_D,
    parameter int BPP_P      = BPP_D,
    parameter int WAIT_WD_P  = WAIT_WD_D,
    localparam int NROWS     = VPIXEL_P / SEGMENTS_P,
    localparam int RW        = (NROWS > 1) ? $clog2(NROWS) : 1,
    localparam int PW        = (BPP_P > 1) ? $clog2(BPP_P) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_enable,
    input  logic [WAIT_WD_P-1:0] i_base_wait,
    input  logic [7:0]           i_blank,
    input  logic [7:0]           i_brightness,
    output logic                 o_tx_start,
    input  logic                 i_tx_ready,
    output logic [PW-1:0]        o_pix_bit,
    output logic [RW-1:0]        o_row,
    output logic                 o_latch,
    output logic                 o_oe_n,
    input  logic                 i_swap_req,
    output logic                 o_swap_ack,
    output logic                 o_frame_done
);

    localparam int TW = WAIT_WD_P + BPP_P;

    state_t               state, nxt;
    logic [PW-1:0]        plane;
    logic [RW-1:0]        srow;
    logic [RW-1:0]        row_q;
    logic [7:0]           bcnt;
    logic                 armed;
    logic                 shifted;
    logic                 swap_ack_q;
    logic [WAIT_WD_P-1:0] base_q;
    logic [WAIT_WD_P-1:0] base_eff;
    logic [TW-1:0]        len;
    logic [TW-1:0]        on;
    logic                 load;
    logic                 expired;
    logic                 lit;
    logic                 last_plane;
    logic                 last_row;

    assign last_plane = (plane == PW'(BPP_P - 1));
    assign last_row   = (srow == RW'(NROWS - 1));
    assign base_eff   = (base_q == '0) ? WAIT_WD_P'(1) : base_q;
    assign len        = TW'(base_eff) << plane;

`ifdef HUB75_SCAN_BRIGHTNESS_EN
    logic [7:0]    bright_q;
    logic [TW+8:0] prod;

    always_ff @(posedge clk) begin
        if (rst)
            bright_q <= '0;
        else if (state == S_LATCH)
            bright_q <= i_brightness;
    end

    assign prod = {9'd0, len} * {{TW{1'b0}}, ({1'b0, bright_q} + 9'd1)};
    assign on   = prod[TW+7:8];
`else
    logic unused_bright;
    assign unused_bright = ^i_brightness;
    assign on            = len;
`endif

    always_comb begin
        nxt          = state;
        o_tx_start   = 1'b0;
        o_latch      = 1'b0;
        load         = 1'b0;
        unique case (state)
            S_IDLE:
                if (i_enable) nxt = S_SHIFT;
            S_SHIFT:
                if (!i_enable) begin
                    nxt = S_WAIT;
                end else if (i_tx_ready) begin
                    o_tx_start = 1'b1;
                    nxt        = S_WAIT;
                end
            S_WAIT:
                if (!armed && expired) begin
                    if (!i_enable || !shifted)
                        nxt = S_IDLE;
                    else if (i_tx_ready)
                        nxt = S_BLANK_PRE;
                end
            S_BLANK_PRE:
                if (bcnt == 8'd0) nxt = S_LATCH;
            S_LATCH: begin
                o_latch = 1'b1;
                nxt     = S_BLANK_POST;
            end
            S_BLANK_POST:
                if (bcnt == 8'd0) begin
                    load = 1'b1;
                    nxt  = S_DISPLAY;
                end
            S_DISPLAY:
                if (i_enable)
                    nxt = S_SHIFT;
                else if (expired)
                    nxt = S_IDLE;
            default:
                nxt = S_IDLE;
        endcase
    end

    // Plane/row advance happens as the next plane starts shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            plane      <= '0;
            srow       <= '0;
            row_q      <= '0;
            bcnt       <= '0;
            armed      <= 1'b0;
            shifted    <= 1'b0;
            swap_ack_q <= 1'b0;
            base_q     <= '0;
        end else begin
            state      <= nxt;
            armed      <= o_tx_start;
            swap_ack_q <= o_frame_done && i_swap_req;
            if (o_tx_start)
                shifted <= 1'b1;
            else if (state == S_IDLE || state == S_LATCH)
                shifted <= 1'b0;
            if (state == S_IDLE) begin
                plane <= '0;
                srow  <= '0;
            end else if (state == S_DISPLAY && nxt == S_SHIFT) begin
                plane <= last_plane ? '0 : plane + PW'(1);
                if (last_plane)
                    srow <= last_row ? '0 : srow + RW'(1);
            end
            if (state == S_WAIT && nxt == S_BLANK_PRE)
                bcnt <= blank_len(i_blank) - 8'd1;
            else if (state == S_LATCH)
                bcnt <= blank_len(i_blank) - 8'd1;
            else if (bcnt != 8'd0)
                bcnt <= bcnt - 8'd1;
            if (state == S_BLANK_PRE && nxt == S_LATCH)
                row_q <= srow;
            if (state == S_LATCH)
                base_q <= i_base_wait;
        end
    end

    hub75_bcm_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .len     (len),
        .on_len  (on),
        .expired (expired),
        .lit     (lit)
    );

    assign o_oe_n       = ~(lit && (state == S_DISPLAY || state == S_SHIFT
                                    || state == S_WAIT));
    assign o_pix_bit    = plane;
    assign o_row        = row_q;
    assign o_swap_ack   = swap_ack_q;
    assign o_frame_done = (state == S_LATCH) && last_plane && last_row;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Scoreboard bench for hub75_scan_ctrl: expected latches and lit
// times are queued by the stimulus and checked by a monitor process.
`timescale 1ns/1ps
module tb_hub75_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_enable = 1'b0;
    logic [15:0] i_base_wait = 16'd4;
    logic [7:0]  i_blank = 8'd2;
    logic [7:0]  i_brightness = 8'd255;
    logic        o_tx_start;
    logic        i_tx_ready;
    logic [2:0]  o_pix_bit;
    logic [4:0]  o_row;
    logic        o_latch;
    logic        o_oe_n;
    logic        i_swap_req = 1'b0;
    logic        o_swap_ack;
    logic        o_frame_done;

    always #5 clk = ~clk;

    hub75_scan_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (i_enable),
        .i_base_wait  (i_base_wait),
        .i_blank      (i_blank),
        .i_brightness (i_brightness),
        .o_tx_start   (o_tx_start),
        .i_tx_ready   (i_tx_ready),
        .o_pix_bit    (o_pix_bit),
        .o_row        (o_row),
        .o_latch      (o_latch),
        .o_oe_n       (o_oe_n),
        .i_swap_req   (i_swap_req),
        .o_swap_ack   (o_swap_ack),
        .o_frame_done (o_frame_done)
    );

    // Shifter model: busy for 10 cycles after each start request.
    int   busy;
    logic stall = 1'b0;
    always @(posedge clk) begin
        if (rst)
            busy <= 0;
        else if (o_tx_start)
            busy <= 10;
        else if (busy > 0)
            busy <= busy - 1;
    end
    assign i_tx_ready = (busy == 0) && !stall;

    typedef struct {
        int row;
        int plane;
        int on;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   run = 0;
    int   pend_on = 0;
    bit   pend = 0;
    int   lat_cnt = 0;
    int   ack_cnt = 0;
    int   ts_cnt = 0;
    logic prev_fd = 1'b0;
    logic prev_req = 1'b0;

    task automatic check(input string name, input longint act,
                         input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    function automatic int on_len(input int base, input int plane,
                                  input int br);
        int l;
        int unused_br;
        unused_br = br;
        l = ((base == 0) ? 1 : base) << plane;
`ifdef HUB75_SCAN_BRIGHTNESS_EN
        return (l * (br + 1)) >> 8;
`else
        return l;
`endif
    endfunction

    task automatic push_frame(input int base, input int br);
        for (int r = 0; r < 32; r++)
            for (int p = 0; p < 8; p++)
                q.push_back('{r, p, on_len(base, p, br)});
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_oe_n"}, o_oe_n, 1);
        check({tag, "_tx_start"}, o_tx_start, 0);
        check({tag, "_latch"}, o_latch, 0);
        check({tag, "_swap_ack"}, o_swap_ack, 0);
        check({tag, "_frame_done"}, o_frame_done, 0);
        check({tag, "_row"}, o_row, 0);
        check({tag, "_pix_bit"}, o_pix_bit, 0);
    endtask

    task automatic wait_fd(input string name, input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!o_frame_done && k < budget);
        check(name, o_frame_done, 1);
    endtask

    task automatic wait_latches(input string name, input int n,
                                input int budget);
        int k = 0;
        while (lat_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, lat_cnt >= n, 1);
    endtask

    // Monitor: pops one expectation per latch and times lit runs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                run     = 0;
                pend    = 0;
                prev_fd = 1'b0;
                prev_req = 1'b0;
            end else begin
                if (!o_oe_n) run++;
                if (o_tx_start) ts_cnt++;
                if ((prev_fd && prev_req) || o_swap_ack)
                    check("swap_ack", o_swap_ack, prev_fd && prev_req);
                if (o_swap_ack) ack_cnt++;
                if (o_frame_done)
                    check("fd_at_latch", o_latch, 1);
                if (o_latch) begin
                    lat_cnt++;
                    if (pend) check("on_len", run, pend_on);
                    run  = 0;
                    pend = 0;
                    check("exp_avail", q.size() > 0, 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check("row", o_row, e.row);
                        check("plane", o_pix_bit, e.plane);
                        check("frame_done", o_frame_done,
                              (e.row == 31 && e.plane == 7));
                        pend    = 1;
                        pend_on = e.on;
                    end
                end
                prev_fd  = o_frame_done;
                prev_req = i_swap_req;
            end
        end
    end

    initial begin
        int ts0;
        int k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");

        // Frame 1: base 4, full brightness, swap requested throughout.
        push_frame(4, 255);
        i_swap_req = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        i_enable = 1'b1;
        wait_fd("frame1_done", 60000);
        @(posedge clk); #1;
        i_base_wait  = 16'd1;
        i_brightness = 8'd127;
        i_swap_req   = 1'b0;
        push_frame(1, 127);
        repeat (4) @(negedge clk);
        check("frame1_latches", lat_cnt, 256);
        check("frame1_acks", ack_cnt, 1);

        // Frame 2: no swap request, then disable after its last latch.
        wait_fd("frame2_done", 30000);
        @(posedge clk); #1;
        i_enable = 1'b0;
        ts0 = ts_cnt;
        repeat (400) @(negedge clk);
        check("frame2_latches", lat_cnt, 512);
        check("frame2_acks", ack_cnt, 1);
        check("no_shift_after_disable", ts_cnt, ts0);
        check("last_plane_on_len", run, pend_on);
        check("idle_oe_n", o_oe_n, 1);
        pend = 0;

        // Reset while row 5 is being displayed.
        i_base_wait  = 16'd2;
        i_brightness = 8'd255;
        push_frame(2, 255);
        @(posedge clk); #1;
        i_enable = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(o_latch && o_row == 5) && k < 20000);
        check("row5_reached", o_latch && o_row == 5, 1);
        k = 0;
        while (o_oe_n && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("row5_lit", o_oe_n, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset("mid_rst");
        q.delete();
        push_frame(2, 255);
        ts0 = lat_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_latches("restart_latches", ts0 + 12, 5000);

        // Shifter stuck busy: display expires, then no latch.
        @(posedge clk); #1;
        stall = 1'b1;
        ts0 = lat_cnt;
        repeat (1000) @(negedge clk);
        check("stall_no_latch", lat_cnt, ts0);
        check("stall_oe_n", o_oe_n, 1);
        @(posedge clk); #1;
        stall = 1'b0;
        wait_latches("stall_resume", ts0 + 1, 300);
        @(posedge clk); #1;
        i_enable = 1'b0;
        repeat (600) @(negedge clk);
        check("final_oe_n", o_oe_n, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
